// File: rtl/pattern_uart_pkg.sv
// Shared types and helpers for the pattern-word UART logger.
package pattern_uart_pkg;

    typedef enum logic [1:0] {IDLE, CHAR, CR, LF} seq_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) return 8'h30 + {4'h0, nib};
        else             return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/pattern_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, idle high.
module uart_tx_byte
    import pattern_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic           r_txd;
    logic [2:0]     w_idx_next;
    logic           w_bit_end;

    assign w_idx_next = r_idx + 3'd1;
    assign w_bit_end  = (r_cnt == '0);
    // NOTE: done is decoded from registered state so a chained start lands on
    // the same edge the stop bit ends, keeping back-to-back bytes gap-free.
    assign done       = (r_state == S_STOP) && w_bit_end;
    assign txd        = r_txd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_MAX;
                        r_idx   <= '0;
                        r_shift <= data;
                        r_txd   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_DATA;
                        r_cnt   <= CNT_MAX;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= CNT_MAX;
                        r_idx <= w_idx_next;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_txd <= r_shift[w_idx_next];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (start) begin
                            r_state <= S_START;
                            r_cnt   <= CNT_MAX;
                            r_idx   <= '0;
                            r_shift <= data;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pattern_uart_tx.sv
// Sends each accepted pattern word as one ASCII hex digit, plus CR LF after the
// last step of the sequence.
module pattern_uart_tx
    import pattern_uart_pkg::*;
#(
    parameter int PAT_W        = 3,
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PAT_W-1:0] in_data,
    input  logic             in_last,
    output logic             txd,
    output logic             busy
);

    seq_state_t r_seq;
    logic       r_last;
    logic       r_ready;
    logic       r_busy;
    logic       w_accept;
    logic       w_start;
    logic       w_done;
    logic [3:0] w_nib;
    logic [7:0] w_byte;

    assign w_accept = in_valid && r_ready;
    assign in_ready = r_ready;
    assign busy     = r_busy;

    always_comb begin
        w_nib              = '0;
        w_nib[PAT_W-1:0]   = in_data;
        w_start            = 1'b0;
        w_byte             = hex_ascii(w_nib);
        case (r_seq)
            IDLE: w_start = w_accept;
            CHAR: begin
                w_start = w_done && r_last;
                w_byte  = ASCII_CR;
            end
            CR: begin
                w_start = w_done;
                w_byte  = ASCII_LF;
            end
            default: w_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_seq   <= IDLE;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_seq)
                IDLE: begin
                    if (w_accept) begin
                        r_seq   <= CHAR;
                        r_last  <= in_last;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                CHAR: begin
                    if (w_done) begin
                        if (r_last) begin
                            r_seq <= CR;
                        end else begin
                            r_seq   <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                CR: begin
                    if (w_done) r_seq <= LF;
                end
                LF: begin
                    if (w_done) begin
                        r_seq   <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_seq <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk   (clk),
        .resetn(resetn),
        .start (w_start),
        .data  (w_byte),
        .txd   (txd),
        .done  (w_done)
    );

endmodule

// File: tb/tb_pattern_uart_tx.sv
// Self-checking bench: per-cycle compare against a queue-based line model,
// plus directed frames with hand-computed bit patterns.
module tb_pattern_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       txd;
    logic       busy;

    logic       w4_valid = 1'b0;
    logic       w4_ready;
    logic [3:0] w4_data = '0;
    logic       w4_last = 1'b0;
    logic       w4_txd;
    logic       w4_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pattern_uart_tx #(.PAT_W(3), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .txd(txd), .busy(busy)
    );

    pattern_uart_tx #(.PAT_W(4), .CLKS_PER_BIT(CPB)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(w4_valid), .in_ready(w4_ready),
        .in_data(w4_data), .in_last(w4_last), .txd(w4_txd), .busy(w4_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: queue of expected line levels -------------
    bit q[$];
    bit m_txd = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_on = 1'b0;

    function automatic int ascii_of(input int v);
        return (v < 10) ? 48 + v : 65 + (v - 10);
    endfunction

    function automatic void push_char(input int c);
        for (int j = 0; j < 10; j++) begin
            bit b;
            b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bit'((c >> (j - 1)) & 1);
            for (int r = 0; r < CPB; r++) q.push_back(b);
        end
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            q.delete();
        end else if (m_ready && in_valid) begin
            push_char(ascii_of(int'(in_data)));
            if (in_last) begin
                push_char(13);
                push_char(10);
            end
        end
        if (q.size() > 0) begin
            m_txd = q.pop_front(); m_busy = 1'b1; m_ready = 1'b0;
        end else begin
            m_txd = 1'b1; m_busy = 1'b0; m_ready = 1'b1;
        end
        m_on = 1'b1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_txd", 32'(txd), 32'(m_txd));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_ready", 32'(in_ready), 32'(m_ready));
        end
    end

    // ---------------- directed helpers ----------------
    function automatic bit frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("idle_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_wide(input logic [3:0] v);
        logic [7:0] got, exp;
        got = '0;
        exp = (v < 4'd10) ? 8'h30 + {4'h0, v} : 8'h41 + {4'h0, v} - 8'd10;
        @(negedge clk);
        w4_valid = 1'b1;
        w4_data  = v;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) begin
                w4_valid = 1'b0;
                check("wide_start", 32'(w4_txd), 32'd0);
            end
            if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) got[(k - 6) / 4] = w4_txd;
            if (k == 40) check("wide_stop", 32'(w4_txd), 32'd1);
            if (k == 41) check("wide_ready", 32'(w4_ready), 32'd1);
        end
        check("wide_char", 32'(got), 32'(exp));
    endtask

    logic [9:0] f35;
    logic [9:0] f30;
    logic [7:0] le_bytes [3];

    initial begin
        f35 = 10'b1001101010;
        f30 = 10'b1001100000;
        le_bytes[0] = 8'h37; le_bytes[1] = 8'h0D; le_bytes[2] = 8'h0A;

        // Reset for three edges, then idle line.
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_txd", 32'(txd), 32'd1);
        end

        // Single character 0x35.
        wait_idle();
        in_valid = 1'b1; in_data = 3'b101; in_last = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k <= 40) check("single_bit", 32'(txd), 32'(f35[(k - 1) / 4]));
            else begin
                check("single_ready", 32'(in_ready), 32'd1);
                check("single_idle", 32'(txd), 32'd1);
            end
        end

        // Line end: '7', CR, LF contiguous.
        wait_idle();
        in_valid = 1'b1; in_data = 3'b111; in_last = 1'b1;
        for (int k = 1; k <= 121; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k <= 120) begin
                check("lineend_bit", 32'(txd),
                      32'(frame_bit(le_bytes[((k - 1) / 4) / 10], ((k - 1) / 4) % 10)));
                if (k == 120) check("lineend_busy_hi", 32'(busy), 32'd1);
            end else begin
                check("lineend_busy", 32'(busy), 32'd0);
                check("lineend_ready", 32'(in_ready), 32'd1);
            end
        end

        // Input changes while busy; held valid gives next accept at t+41.
        wait_idle();
        in_valid = 1'b1; in_data = 3'b101; in_last = 1'b0;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            if (k == 5) in_data = 3'b000;
            if (k == 42) in_valid = 1'b0;
            if (k <= 40) check("hold_bit0", 32'(txd), 32'(f35[(k - 1) / 4]));
            else if (k == 41) begin
                check("hold_gap_txd", 32'(txd), 32'd1);
                check("hold_gap_ready", 32'(in_ready), 32'd1);
            end else if (k <= 81) check("hold_bit1", 32'(txd), 32'(f30[(k - 42) / 4]));
            else check("hold_end", 32'(txd), 32'd1);
        end

        // Reset during data bit 3 abandons the frame and its CR LF.
        wait_idle();
        in_valid = 1'b1; in_data = 3'b101; in_last = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k == 18) resetn = 1'b0;
            if (k == 19) resetn = 1'b1;
            if (k >= 19) begin
                check("midrst_txd", 32'(txd), 32'd1);
                check("midrst_busy", 32'(busy), 32'd0);
            end
        end

        // Randomized traffic, including sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 3'($urandom);
            in_last  = ($urandom_range(0, 2) == 0);
            resetn   = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        in_valid = 1'b0;
        wait_idle();

        // Four-bit pattern words on the wide instance.
        run_wide(4'hA);
        run_wide(4'hF);
        run_wide(4'h0);
        run_wide(4'h9);
        run_wide(4'($urandom));
        run_wide(4'($urandom));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
